// File: rtl/tamarisc_pkg.sv
// Shared definitions for the tamarisc fetch path.
//   XLEN          : architectural word width
//   fetch_state_e : fetch FSM states (IDLE, REQ, WAIT)
//   fetch_entry_t : one buffered instruction together with the PC it came from
//   word_align()  : clears the byte-offset bits of an address
package tamarisc_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding fetch_entry_t records.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   push_i         : write push_data_i (ignored when full unless popping)
//   push_data_i    : entry to write
//   pop_i          : drop the head entry (ignored when empty)
//   flush_i        : empty the FIFO; overrides push and pop
//   head_o         : head entry, all-zero while empty
//   count_o        : number of stored entries
//   full_o/empty_o : occupancy flags
module fetch_fifo
  import tamarisc_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i) & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Head is gated so that an empty FIFO presents zeros rather than stale data.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads at the current PC, keeps at most
// one request outstanding, buffers returned instructions with their PCs and
// hands them to decode over a valid/ready handshake.
// Ports:
//   clk_i, rst_n_i  : clock, asynchronous active-low reset
//   pc_i            : current PC (low two bits ignored)
//   incr_pc_o       : PC advance strobe, high in the cycle a request is granted
//   imem_req_o      : memory read request
//   imem_addr_o     : word-aligned read address derived from pc_i
//   imem_gnt_i      : memory accepted the request this cycle
//   imem_rvalid_i   : read data valid
//   imem_rdata_i    : read data
//   instr_valid_o   : buffered instruction available
//   instr_o         : head instruction
//   instr_pc_o      : PC of the head instruction
//   instr_ready_i   : decode takes the head instruction
//   flush_i         : drop buffered and in-flight instructions
module fetch_unit
  import tamarisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            incr_pc_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  input  logic            flush_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            discard_q, discard_d;

  logic            grant, resp, push, pop, outstanding, room;
  logic [CW-1:0]   count_q, count_next;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    push_entry, head;

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = word_align(pc_i);
  assign grant       = imem_req_o & imem_gnt_i;
  assign incr_pc_o   = grant;

  // Responses only count while a request is actually outstanding.
  assign resp = (state_q == WAIT) & imem_rvalid_i;
  assign push = resp & ~discard_q & ~flush_i & (~fifo_full | pop);
  assign pop  = instr_valid_o & instr_ready_i & ~flush_i;

  // A response still pending after this cycle reserves a FIFO slot.
  assign outstanding = (state_q == WAIT) & ~imem_rvalid_i;

  // Occupancy after this cycle's push/pop/flush, used for the room decision.
  always_comb begin
    count_next = count_q;
    if (flush_i)          count_next = '0;
    else if (push & ~pop) count_next = count_q + CW'(1);
    else if (pop & ~push) count_next = count_q - CW'(1);
  end

  assign room = (int'(count_next) + int'(outstanding)) < DEPTH;

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: begin
        if (room) state_d = REQ;
      end
      REQ: begin
        // The request stays up through a flush; a grant during the flush
        // is taken but its data will be thrown away.
        if (imem_gnt_i) begin
          state_d   = WAIT;
          req_pc_d  = imem_addr_o;
          discard_d = flush_i;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          // A response coinciding with a flush is dropped by the push gate,
          // so nothing is left to discard afterwards.
          discard_d = 1'b0;
          state_d   = room ? REQ : IDLE;
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      req_pc_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
    end
  end

  assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .flush_i    (flush_i),
    .head_o     (head),
    .count_o    (count_q),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting between the program counter and decode. It issues word reads to instruction memory at the current PC and pulses the PC increment on each accepted request. Returned instructions are buffered, each paired with its PC, in a small FIFO and presented to decode on a valid/ready handshake. It allows one outstanding memory request and supports a flush that empties the buffer and discards any in-flight response.

## Interface
Parameters:
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  reset; asynchronous, active-low
- pc_i  input  32  current PC from the PC register
- incr_pc_o  output  1  PC advance strobe, = imem_req_o & imem_gnt_i (combinational)
- imem_req_o  output  1  memory read request
- imem_addr_o  output  32  read address, {pc_i[31:2], 2'b00}
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  read data valid
- imem_rdata_i  input  32  read data
- instr_valid_o  output  1  FIFO head valid
- instr_o  output  32  FIFO head instruction
- instr_pc_o  output  32  FIFO head PC
- instr_ready_i  input  1  decode accepts head
- flush_i  input  1  drop buffered and in-flight instructions

## Operation
- FSM states: IDLE (no request outstanding, FIFO lacks room), REQ (imem_req_o=1, awaiting grant), WAIT (granted, awaiting rvalid).
- Room condition: count_next + outstanding < DEPTH, where count_next includes this cycle's push/pop.
- IDLE→REQ when room. REQ→WAIT on gnt. WAIT→REQ on rvalid if room, else →IDLE.
- On grant: capture pc_i into req_pc; incr_pc_o=1 in the same cycle. The PC register updates at the next edge.
- imem_addr_o is stable while REQ is held, because the PC only moves on a grant.
- On rvalid in WAIT: push {req_pc, imem_rdata_i} into the FIFO unless the discard flag is set.
- Pop when instr_valid_o & instr_ready_i. Push and pop in the same cycle are legal at any count.
- flush_i (highest priority):
  - FIFO count→0.
  - If in WAIT, set discard. The next rvalid is dropped and clears discard.
  - If in REQ, the request stays asserted (address unchanged). A grant in the flush cycle is honoured, with discard set for it.
- rvalid outside WAIT is ignored. gnt outside REQ is ignored.
- pc_i[1:0] are ignored.

## Timing
- Reset values: imem_req_o=0, incr_pc_o=0, imem_addr_o follows pc_i, instr_valid_o=0, instr_o=0, instr_pc_o=0, state=IDLE, count=0, discard=0.
- Earliest request is the first cycle after reset deassertion.
- Grant latency 0..n cycles. rvalid arrives no earlier than the cycle after the grant.
- rvalid at cycle N → instr_valid_o=1 at N+1 (registered FIFO, no bypass).
- A new request may assert in the same cycle as rvalid. Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Reset mid-request: all state clears immediately. A late rvalid after reset is ignored (state IDLE/REQ).

## Structure
- Shared package tamarisc_pkg: XLEN=32, fetch_state_e {IDLE, REQ, WAIT}, fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: parameterised sync FIFO of fetch_entry_t with push/pop/flush/count, full/empty.
- Top-level holds the FSM, req_pc and discard.

## Test plan
- Reset release with gnt tied 1 and 1-cycle rvalid, rdata=0x00000013, pc starting 0: entries with PCs 0x0, 0x4, 0x8 appear, one incr_pc_o pulse per grant.
- instr_ready_i=0 with DEPTH=2: after 2 pushes imem_req_o stays 0 (IDLE). Raise ready → request resumes the next cycle.
- gnt delayed 3 cycles: imem_req_o and imem_addr_o held constant, incr_pc_o single-cycle pulse on the grant.
- flush_i while in WAIT with FIFO holding 1 entry: instr_valid_o=0 the next cycle, the following rvalid data (0xDEADBEEF) is never presented, the next fetch is presented.
- Simultaneous push and pop at count=DEPTH-1: count unchanged, order preserved, PCs monotonically +4.
- rst_n_i asserted while in WAIT, then released: outputs at reset values immediately, a stray rvalid is ignored, and fetching restarts cleanly.
